// File: rtl/system_pkg.sv
// system_pkg: shared widths, access FSM states and address command codes
// for the AVR-to-SRAM bridge.
package system_pkg;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        CMD_NOP = 3'b000,
        CMD_CLR = 3'b001,
        CMD_INC = 3'b010
    } cmd_e;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/system_sram_ctrl.sv
// sram_ctrl: single-access SRAM sequencer (IDLE/SETUP/STROBE/DONE) with
// registered, glitch-free strobes and read/write data holding registers.
module sram_ctrl
    import system_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ce_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] avr_data_i,
    input  logic [DATA_W-1:0] sram_data_i,
    output logic              idle_o,
    output logic              inc_o,
    output logic              avr_drv_o,
    output logic              sram_dir_o,
    output logic [DATA_W-1:0] read_data_o,
    output logic [DATA_W-1:0] write_data_o,
    output logic              sram_ce_no,
    output logic              sram_oe_no,
    output logic              sram_we_no
);

    state_e            state_q, state_d;
    logic              op_we_q, op_we_d;
    logic              capture;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] write_data;
    logic              sram_dir, dir_d;
    logic              ce_n_q, oe_n_q, we_n_q;
    logic              ce_n_d, oe_n_d, we_n_d;

    assign capture = (state_q == ST_IDLE) && ce_i;

    // strobes are decoded from the next state so they change with, not after, the state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ce_i ? ST_SETUP : ST_IDLE;
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: state_d = ST_DONE;
            ST_DONE:   state_d = ce_i ? ST_DONE : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        op_we_d = capture ? we_i : op_we_q;
        ce_n_d  = !(state_d == ST_SETUP || state_d == ST_STROBE);
        oe_n_d  = !(state_d == ST_STROBE && !op_we_d);
        we_n_d  = !(state_d == ST_STROBE && op_we_d);
        dir_d   = op_we_d && !ce_n_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            op_we_q    <= 1'b0;
            read_data  <= '0;
            write_data <= '0;
            sram_dir   <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            op_we_q  <= op_we_d;
            sram_dir <= dir_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            if (capture && we_i) write_data <= avr_data_i;
            if (state_q == ST_STROBE && !op_we_q) read_data <= sram_data_i;
        end
    end

    assign idle_o       = state_q == ST_IDLE;
    assign inc_o        = state_q == ST_STROBE;
    assign avr_drv_o    = ce_i && !op_we_q && state_q != ST_IDLE;
    assign sram_dir_o   = sram_dir;
    assign read_data_o  = read_data;
    assign write_data_o = write_data;
    assign sram_ce_no   = ce_n_q;
    assign sram_oe_no   = oe_n_q;
    assign sram_we_no   = we_n_q;

endmodule

// File: rtl/system_sreg.sv
// sreg: SRAM address register with serial MSB-first load and clear/increment commands.
// SYSTEM_AUTOINC_EN adds a post-access increment driven by the access FSM.
module sreg
    import system_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              idle_i,
    input  logic              oe_ni,
    input  logic              ce_i,
    input  logic              si_i,
    input  logic [2:0]        ctrl_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] buffer;
    logic [ADDR_W-1:0] buffer_d;
    logic              shift_en;
    logic              cmd_en;

    assign shift_en = idle_i && !oe_ni && !ce_i;
    assign cmd_en   = idle_i && oe_ni;

    // serial shift outranks commands; inc_i only fires outside IDLE so never collides
    always_comb begin
        buffer_d = shift_en                        ? {buffer[ADDR_W-2:0], si_i} :
                   (cmd_en && ctrl_i == CMD_CLR)   ? '0 :
                   (cmd_en && ctrl_i == CMD_INC)   ? addr_inc(buffer) : buffer;
`ifdef SYSTEM_AUTOINC_EN
        if (inc_i) buffer_d = addr_inc(buffer);
`endif
    end

`ifndef SYSTEM_AUTOINC_EN
    logic unused_inc;
    assign unused_inc = inc_i;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) buffer <= '0;
        else         buffer <= buffer_d;
    end

    assign addr_o = buffer;

endmodule

// File: rtl/system.sv
// system: AVR parallel-bus to asynchronous SRAM bridge.
// Define SYSTEM_AUTOINC_EN to advance the address after every access.
module system
    import system_pkg::*;
(
    input  logic              avr_clk,
    input  logic              avr_rst_n,
    inout  wire  [DATA_W-1:0] avr_data,
    input  logic [2:0]        avr_ctrl,
    input  logic              avr_ce,
    input  logic              avr_we,
    input  logic              avr_oe,
    input  logic              avr_si,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    logic              idle;
    logic              inc;
    logic              avr_drv;
    logic              sram_dir;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] write_data;

    sreg sreg0 (
        .clk_i  (avr_clk),
        .rst_ni (avr_rst_n),
        .idle_i (idle),
        .oe_ni  (avr_oe),
        .ce_i   (avr_ce),
        .si_i   (avr_si),
        .ctrl_i (avr_ctrl),
        .inc_i  (inc),
        .addr_o (sram_addr)
    );

    sram_ctrl sram0 (
        .clk_i        (avr_clk),
        .rst_ni       (avr_rst_n),
        .ce_i         (avr_ce),
        .we_i         (avr_we),
        .avr_data_i   (avr_data),
        .sram_data_i  (sram_data),
        .idle_o       (idle),
        .inc_o        (inc),
        .avr_drv_o    (avr_drv),
        .sram_dir_o   (sram_dir),
        .read_data_o  (read_data),
        .write_data_o (write_data),
        .sram_ce_no   (sram_ce_n),
        .sram_oe_no   (sram_oe_n),
        .sram_we_no   (sram_we_n)
    );

    assign avr_data  = avr_drv  ? read_data  : {DATA_W{1'bz}};
    assign sram_data = sram_dir ? write_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_system.sv
// tb_system: randomized scoreboard bench for the AVR-SRAM bridge with an SRAM model;
// undriven buses are pulled up so a released bus reads 0xFF.
module tb_system;

    localparam int MASK = 32'h1FFFFF;

    logic        avr_clk = 1'b0;
    logic        avr_rst_n = 1'b0;
    logic [2:0]  avr_ctrl = 3'd0;
    logic        avr_ce = 1'b0;
    logic        avr_we = 1'b0;
    logic        avr_oe = 1'b1;
    logic        avr_si = 1'b0;
    logic [20:0] sram_addr;
    logic        sram_ce_n, sram_oe_n, sram_we_n;
    wire  [7:0]  avr_data;
    wire  [7:0]  sram_data;

    logic [7:0]  tb_data = 8'h00;
    logic        tb_drv = 1'b0;
    logic [7:0]  sram_rd;
    logic [7:0]  mem [int];
    logic [7:0]  ref_mem [int];
    int          ref_addr = 0;
    logic [28:0] wq [$];
    logic [28:0] rq [$];
    logic        rd_pend = 1'b0;
    logic [7:0]  rd_exp = 8'h00;
    int          nvec = 0;
    int          nerr = 0;

    assign avr_data  = tb_drv ? tb_data : 8'hzz;
    assign sram_data = sram_oe_n ? 8'hzz : sram_rd;

    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (avr_data[i]);
        pullup (sram_data[i]);
    end

    system dut (
        .avr_clk   (avr_clk),
        .avr_rst_n (avr_rst_n),
        .avr_data  (avr_data),
        .avr_ctrl  (avr_ctrl),
        .avr_ce    (avr_ce),
        .avr_we    (avr_we),
        .avr_oe    (avr_oe),
        .avr_si    (avr_si),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n)
    );

    initial forever #5 avr_clk = ~avr_clk;

    function automatic logic [7:0] dflt(input int a);
        return 8'(a) ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // SRAM model
    always @(sram_addr or sram_oe_n)
        sram_rd = mem.exists(int'(sram_addr)) ? mem[int'(sram_addr)] : dflt(int'(sram_addr));

    always @(posedge avr_clk)
        if (!sram_we_n) mem[int'(sram_addr)] = sram_data;

    // monitor: pops the scoreboard whenever the DUT strobes the SRAM
    always @(negedge avr_clk) begin
        logic [28:0] e;
        if (rd_pend) begin
            check("rd_avr_data", 32'(avr_data), 32'(rd_exp));
            check("rd_read_data", 32'(dut.sram0.read_data), 32'(rd_exp));
            rd_pend = 1'b0;
        end
        if (!sram_we_n) begin
            if (wq.size() == 0) check("unexpected_write", 32'(sram_addr), 32'hFFFFFFFF);
            else begin
                e = wq.pop_front();
                check("wr_addr", 32'(sram_addr), 32'(e[28:8]));
                check("wr_data", 32'(sram_data), 32'(e[7:0]));
                check("wr_ce_n", 32'(sram_ce_n), 32'd0);
            end
        end
        if (!sram_oe_n) begin
            check("no_contention", 32'(dut.sram0.sram_dir), 32'd0);
            if (rq.size() == 0) check("unexpected_read", 32'(sram_addr), 32'hFFFFFFFF);
            else begin
                e = rq.pop_front();
                check("rd_addr", 32'(sram_addr), 32'(e[28:8]));
                rd_exp  = e[7:0];
                rd_pend = 1'b1;
            end
        end
    end

    task automatic tick;
        @(posedge avr_clk);
        #1;
    endtask

    task automatic shift(input int n, input logic [20:0] v);
        avr_oe = 1'b0;
        avr_ce = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            avr_si   = v[i];
            avr_ctrl = 3'($urandom);
            tick;
            ref_addr = ((ref_addr << 1) | int'(v[i])) & MASK;
        end
        avr_oe   = 1'b1;
        avr_ctrl = 3'd0;
    endtask

    task automatic cmd(input logic [2:0] c);
        avr_ctrl = c;
        tick;
        avr_ctrl = 3'd0;
        if (c == 3'b001) ref_addr = 0;
        if (c == 3'b010) ref_addr = (ref_addr + 1) & MASK;
    endtask

    task automatic access(input logic w, input logic [7:0] d, input int hold);
        if (w) begin
            ref_mem[ref_addr] = d;
            wq.push_back({21'(ref_addr), d});
        end else rq.push_back({21'(ref_addr), ref_rd(ref_addr)});
        avr_we   = w;
        avr_ce   = 1'b1;
        tb_data  = d;
        tb_drv   = w;
        avr_ctrl = 3'd0;
        avr_oe   = 1'b1;
        tick;
        tb_drv   = 1'b0;
        avr_ctrl = 3'($urandom);
        avr_oe   = 1'($urandom);
        avr_si   = 1'($urandom);
        tick;
        tick;
        repeat (1 + hold) tick;
        avr_ce = 1'b0;
        #1;
        if (!w) check("rd_release", 32'(avr_data), 32'hFF);
        tick;
        avr_ctrl = 3'd0;
        avr_oe   = 1'b1;
`ifdef SYSTEM_AUTOINC_EN
        ref_addr = (ref_addr + 1) & MASK;
`endif
        if (w) check("wr_dir_idle", 32'(dut.sram0.sram_dir), 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        mem[16]     = 8'h3C;
        ref_mem[16] = 8'h3C;
        repeat (3) tick;
        check("rst_buffer", 32'(dut.sreg0.buffer), 32'd0);
        check("rst_read_data", 32'(dut.sram0.read_data), 32'd0);
        check("rst_write_data", 32'(dut.sram0.write_data), 32'd0);
        check("rst_dir", 32'(dut.sram0.sram_dir), 32'd0);
        check("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h7);
        check("rst_avr_bus", 32'(avr_data), 32'hFF);
        check("rst_sram_bus", 32'(sram_data), 32'hFF);
        avr_rst_n = 1'b1;
        ref_addr  = 0;
        tick;
        shift(15, 21'b100110011001111);
        check("load_buffer", 32'(dut.sreg0.buffer), 32'h004CCF);
        check("load_addr", 32'(sram_addr), 32'h004CCF);
        check("load_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h7);
        cmd(3'b001);
        shift(5, 21'h10);
        access(1'b1, 8'hA5, 0);
        check("wr_write_data", 32'(dut.sram0.write_data), 32'hA5);
        mem[16]     = 8'h3C;
        ref_mem[16] = 8'h3C;
        cmd(3'b001);
        shift(5, 21'h10);
        access(1'b0, 8'h00, 2);
        check("rd_hold_read_data", 32'(dut.sram0.read_data), 32'h3C);
        shift(21, 21'h1FFFFF);
        check("all_ones", 32'(sram_addr), 32'h1FFFFF);
        cmd(3'b010);
        check("inc_wrap", 32'(dut.sreg0.buffer), 32'd0);
        shift(9, 21'h1A7);
        cmd(3'b001);
        check("clear", 32'(dut.sreg0.buffer), 32'd0);
        shift(6, 21'h2B);
        wq.push_back({21'(ref_addr), 8'h96});
        ref_mem[ref_addr] = 8'h96;
        avr_we  = 1'b1;
        avr_ce  = 1'b1;
        tb_data = 8'h96;
        tb_drv  = 1'b1;
        tick;
        tb_drv = 1'b0;
        tick;
        avr_rst_n = 1'b0;
        avr_ce    = 1'b0;
        tick;
        check("abort_we_n", 32'(sram_we_n), 32'd1);
        check("abort_ce_n", 32'(sram_ce_n), 32'd1);
        check("abort_dir", 32'(dut.sram0.sram_dir), 32'd0);
        check("abort_buffer", 32'(dut.sreg0.buffer), 32'd0);
        avr_rst_n = 1'b1;
        ref_addr  = 0;
        tick;
        shift(4, 21'hB);
        check("abort_idle_shift", 32'(sram_addr), 32'hB);
`ifdef SYSTEM_AUTOINC_EN
        cmd(3'b001);
        shift(3, 21'd5);
        access(1'b0, 8'h00, 0);
        access(1'b0, 8'h00, 0);
        check("autoinc_addr", 32'(sram_addr), 32'd7);
`endif
        repeat (120) begin
            d = 8'($urandom);
            case ($urandom_range(0, 5))
                0: shift($urandom_range(1, 21), 21'($urandom));
                1: cmd(3'($urandom));
                2: access(1'b1, d, $urandom_range(0, 2));
                3: access(1'b0, 8'h00, $urandom_range(0, 2));
                4: begin
                    access(1'b1, d, 0);
                    access(1'b0, 8'h00, $urandom_range(0, 2));
                end
                default: repeat ($urandom_range(1, 3)) tick;
            endcase
            check("addr_track", 32'(sram_addr), 32'(ref_addr));
        end
        repeat (3) tick;
        check("wq_drained", 32'(wq.size()), 32'd0);
        check("rq_drained", 32'(rq.size()), 32'd0);
        check("rd_settled", 32'(rd_pend), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/system.md
SYSTEM -- requirements
Module: system

Interface
REQ-001 avr_clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 avr_rst_n  in  1  reset, synchronous, active-low.
REQ-003 avr_data  inout  8  AVR data bus; driven by the block only during a read access, otherwise high-Z.
REQ-004 avr_ctrl  in  3  address command: 000 nop, 001 clear address, 010 increment address, others nop.
REQ-005 avr_ce  in  1  access strobe, active-high; one SRAM access per assertion.
REQ-006 avr_we  in  1  access type, sampled with avr_ce: 0 = read, 1 = write.
REQ-007 avr_oe  in  1  serial address load enable, active-low.
REQ-008 avr_si  in  1  serial address data, MSB first.
REQ-009 sram_addr  out  21  SRAM address, equal to the address shift register at all times.
REQ-010 sram_data  inout  8  SRAM data bus; driven only when sram_dir = 1.
REQ-011 sram_ce_n / sram_oe_n / sram_we_n  out  1 each  SRAM strobes, active-low.

Function
REQ-012 Address load: in IDLE, with avr_oe = 0 and avr_ce = 0, each edge does buffer <= {buffer[19:0], avr_si}.
REQ-013 Address commands: in IDLE with avr_oe = 1, avr_ctrl 001 sets buffer to 0 and 010 adds 1 modulo 2^21 (0x1FFFFF wraps to 0x000000).
REQ-014 Priority: a serial shift wins over avr_ctrl; neither has any effect outside IDLE.
REQ-015 Access FSM states: IDLE, SETUP, STROBE, DONE, each lasting exactly one cycle except IDLE and DONE.
REQ-016 IDLE -> SETUP when avr_ce = 1; avr_we is captured as the op, and on a write avr_data is latched into write_data.
REQ-017 SETUP: sram_ce_n = 0; on a write sram_dir = 1 and sram_data = write_data.
REQ-018 STROBE: a read asserts sram_oe_n = 0 and latches sram_data into read_data at the end of the cycle; a write asserts sram_we_n = 0 with data held.
REQ-019 DONE: all strobes are high and sram_dir = 0; the FSM stays in DONE until avr_ce = 0, then returns to IDLE.
REQ-020 avr_data is driven with read_data whenever avr_ce = 1 and the captured op is read; otherwise it is high-Z.
REQ-021 sram_data never drives in the same cycle that sram_oe_n = 0, which guarantees no bus contention.

Reset
REQ-022 While avr_rst_n = 0 at an edge: buffer, read_data and write_data are 0; sram_dir = 0; all SRAM strobes are 1; the FSM is in IDLE; both buses are high-Z.
REQ-023 Reset asserted mid-access aborts the access: strobes are deasserted at that edge and no address increment occurs.

Configuration
REQ-024 Macro SYSTEM_AUTOINC_EN: when defined, buffer increments by 1 (with wrap) on the STROBE->DONE transition of every access; when undefined, the address changes only via REQ-012/013.

Structure
REQ-025 A shared package holds the FSM state enum, avr_ctrl command codes, and the widths ADDR_W = 21 and DATA_W = 8.
REQ-026 Sub-module sreg, instance sreg0, holds the 21-bit register named buffer.
REQ-027 Sub-module sram_ctrl, instance sram0, holds the FSM, read_data, write_data and sram_dir.
REQ-028 The hierarchical names dut.sreg0.buffer, dut.sram0.read_data, dut.sram0.write_data and dut.sram0.sram_dir are fixed and are probed by benches.

Verification
REQ-029 Reset, then avr_oe = 0 with avr_si = 1,0,0,1,1,0,0,1,1,0,0,1,1,1,1 for 15 edges, then avr_oe = 1 -> buffer = sram_addr = 0x004CCF, strobes stay high.
REQ-030 Address 0x000010, avr_data = 0xA5, avr_we = 1, avr_ce pulse -> sram_ce_n/sram_we_n low for 1 cycle with sram_data = 0xA5, and sram_dir returns to 0.
REQ-031 SRAM model returns 0x3C at 0x000010, avr_we = 0, avr_ce held -> read_data = 0x3C after STROBE; avr_data = 0x3C until avr_ce falls, then high-Z.
REQ-032 buffer = 0x1FFFFF, avr_ctrl = 010 for one cycle -> buffer = 0x000000; avr_ctrl = 001 -> buffer = 0.
REQ-033 avr_rst_n low during STROBE of a write -> sram_we_n = 1, sram_dir = 0 at that edge and the FSM returns to IDLE.
REQ-034 With SYSTEM_AUTOINC_EN defined, two back-to-back reads from 0x000005 -> accesses at 0x000005 and 0x000006.
